// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, bubble encoding, fetch FSM states and IF/ID entry type.
package if_fetch_pkg;

    localparam int WIDTH_PC   = 32;
    localparam int WIDTH_INST = 32;

    // addi x0,x0,0
    localparam logic [WIDTH_INST-1:0] NOP_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_S_IDLE = 2'd0,
        IF_S_REQ  = 2'd1,
        IF_S_WAIT = 2'd2,
        IF_S_PEND = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [WIDTH_PC-1:0]   pc;
        logic [WIDTH_INST-1:0] inst;
    } if_entry_t;

    function automatic logic [WIDTH_PC-1:0] word_align(input logic [WIDTH_PC-1:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_out_buf.sv
// if_out_buf: IF/ID-facing output buffer plus one-entry pend register.
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         squash presented instruction (redirect)
//   stop_i          IF/ID stall; a valid entry is held while high
//   load_i          present load_data_i on this edge
//   load_data_i     {pc, inst} to present
//   pend_we_i       capture pend_data_i into the pend register
//   pend_data_i     {pc, inst} parked while the buffer is stalled
//   out_o, valid_o  presented entry and its valid flag
//   pend_o          parked entry
module if_out_buf
    import if_fetch_pkg::*;
#(
    parameter logic [WIDTH_INST-1:0] NOP_INST = NOP_ENC
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush_i,
    input  logic      stop_i,
    input  logic      load_i,
    input  if_entry_t load_data_i,
    input  logic      pend_we_i,
    input  if_entry_t pend_data_i,
    output if_entry_t out_o,
    output logic      valid_o,
    output if_entry_t pend_o
);

    if_entry_t out_q, out_d, pend_q;
    logic      valid_q, valid_d;

    // flush > stall hold > load > bubble; a bubble keeps the old pc
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (flush_i) begin
            valid_d    = 1'b0;
            out_d.inst = NOP_INST;
        end else if (!(valid_q && stop_i)) begin
            valid_d = load_i;
            out_d   = load_i ? load_data_i : '{pc: out_q.pc, inst: NOP_INST};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '{pc: '0, inst: NOP_INST};
            valid_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            if (pend_we_i)
                pend_q <= pend_data_i;
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign pend_o  = pend_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: fetch PC, single-outstanding imem requests, IF/ID producer with stall and redirect.
//   clk, rst_n                      clock, asynchronous active-low reset
//   stop_IF                         IF/ID stall, output buffer holds while high
//   redirect_valid, redirect_pc     EX redirect: flush and restart at redirect_pc (word aligned)
//   imem_req, imem_addr             request valid and word-aligned address
//   imem_ready                      memory accepts the request this cycle
//   imem_rvalid, imem_rdata         response strobe and instruction word
//   pc_o, inst_o, inst_valid        presented instruction to IF/ID
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [WIDTH_PC-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH_INST-1:0] NOP_INST = NOP_ENC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stop_IF,
    input  logic                  redirect_valid,
    input  logic [WIDTH_PC-1:0]   redirect_pc,
    output logic                  imem_req,
    output logic [WIDTH_PC-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [WIDTH_INST-1:0] imem_rdata,
    output logic [WIDTH_PC-1:0]   pc_o,
    output logic [WIDTH_INST-1:0] inst_o,
    output logic                  inst_valid
);

    if_state_e           state_q;
    logic [WIDTH_PC-1:0] pc_q, fetch_pc_q;
    logic                discard_q;

    if_entry_t out_e, pend_e, load_e;
    logic      buf_stall, rdata_ok, load, pend_we;

    assign imem_req  = (state_q == IF_S_REQ) && !redirect_valid;
    assign imem_addr = pc_q;

    // buffer cannot take new data this edge
    assign buf_stall = inst_valid && stop_IF;
    // response belongs to the live request and survives this edge
    assign rdata_ok  = (state_q == IF_S_WAIT) && imem_rvalid && !discard_q && !redirect_valid;
    assign load      = (rdata_ok && !buf_stall) ||
                       ((state_q == IF_S_PEND) && !redirect_valid && !stop_IF);
    assign pend_we   = rdata_ok && buf_stall;
    assign load_e    = (state_q == IF_S_PEND) ? pend_e : '{pc: fetch_pc_q, inst: imem_rdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IF_S_IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            case (state_q)
                IF_S_IDLE: state_q <= IF_S_REQ;
                IF_S_REQ: begin
                    if (redirect_valid) begin
                        pc_q <= word_align(redirect_pc);
                    end else if (imem_ready) begin
                        fetch_pc_q <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        state_q    <= IF_S_WAIT;
                    end
                end
                IF_S_WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= word_align(redirect_pc);
                        // response still in flight must be dropped when it lands
                        discard_q <= !imem_rvalid;
                        if (imem_rvalid)
                            state_q <= IF_S_REQ;
                    end else if (imem_rvalid) begin
                        discard_q <= 1'b0;
                        state_q   <= (discard_q || !buf_stall) ? IF_S_REQ : IF_S_PEND;
                    end
                end
                IF_S_PEND: begin
                    if (redirect_valid) begin
                        pc_q    <= word_align(redirect_pc);
                        state_q <= IF_S_REQ;
                    end else if (!stop_IF) begin
                        state_q <= IF_S_REQ;
                    end
                end
                default: state_q <= IF_S_IDLE;
            endcase
        end
    end

    if_out_buf #(.NOP_INST(NOP_INST)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .stop_i      (stop_IF),
        .load_i      (load),
        .load_data_i (load_e),
        .pend_we_i   (pend_we),
        .pend_data_i ('{pc: fetch_pc_q, inst: imem_rdata}),
        .out_o       (out_e),
        .valid_o     (inst_valid),
        .pend_o      (pend_e)
    );

    assign pc_o   = out_e.pc;
    assign inst_o = out_e.inst;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch front end and the producer side of the IF/ID pipeline register. Holds the fetch PC, issues single-outstanding requests to instruction memory and absorbs variable memory latency. Presents {pc_o, inst_o, inst_valid} to IF/ID, honours the same stop_IF stall that freezes IF/ID, and squashes wrong-path fetches on an EX-stage redirect.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven when inst_valid=0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stop_IF  in  1  IF/ID stall; the output buffer must hold while high
redirect_valid  in  1  branch/jump taken in EX; flush and restart fetch
redirect_pc  in  `WIDTH_PC  new fetch target; bits [1:0] forced to 0
imem_req  out  1  request valid
imem_addr  out  `WIDTH_PC  request address (word aligned)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid; never in the acceptance cycle
imem_rdata  in  `WIDTH_INST  instruction word
pc_o  out  `WIDTH_PC  PC of presented instruction, to IF/ID pc
inst_o  out  `WIDTH_INST  presented instruction, to IF/ID inst
inst_valid  out  1  pc_o/inst_o hold a real instruction

Behaviour:
- Clocking: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: state=S_IDLE, pc_q=RESET_PC, discard=0, inst_valid=0, inst_o=NOP_INST, pc_o=0, imem_req=0.
- imem_req = (state==S_REQ) && !redirect_valid. imem_addr = pc_q (combinational from the register).
- S_IDLE: go to S_REQ on the next edge. No request is issued in this state.
- S_REQ:
  - redirect_valid: pc_q<=redirect_pc; stay in S_REQ.
  - else imem_ready: fetch_pc<=pc_q; pc_q<=pc_q+4 (wraps mod 2^32); go to S_WAIT.
- S_WAIT:
  - redirect_valid with imem_rvalid: drop the data; pc_q<=redirect_pc; go to S_REQ.
  - redirect_valid without imem_rvalid: pc_q<=redirect_pc; discard<=1; stay in S_WAIT.
  - imem_rvalid with discard=1: drop the data; discard<=0; go to S_REQ.
  - imem_rvalid with discard=0 and the buffer free (!(inst_valid&&stop_IF)): load the output buffer with {fetch_pc, rdata}; go to S_REQ.
  - imem_rvalid with discard=0 and the buffer stalled: pend_pc<=fetch_pc; pend_inst<=rdata; go to S_PEND.
- S_PEND:
  - redirect_valid: drop the pending entry; pc_q<=redirect_pc; go to S_REQ.
  - else !stop_IF: move pend into the output buffer; go to S_REQ.
- Output buffer priority per edge: reset > redirect (inst_valid<=0, inst_o<=NOP_INST) > stall hold (inst_valid&&stop_IF) > load > bubble (inst_valid<=0, inst_o<=NOP_INST, pc_o holds).
- IF/ID consumes the buffer on every edge where stop_IF=0, so a valid instruction stays valid for exactly one cycle unless stalled.
- Best-case throughput: one instruction per 2 cycles with zero-wait memory (S_REQ→S_WAIT→S_REQ).
- Latency: the output becomes valid on the edge after imem_rvalid.
- Reset asserted mid-transaction: all state is cleared. Any later rvalid is ignored because the block is in S_IDLE or S_REQ and not waiting for data.
- At most one outstanding request. No request is issued outside S_REQ.

Decomposition:
- `WIDTH_PC, `WIDTH_INST and the NOP encoding live in the shared param.v.
- Add state encodings IF_S_IDLE/REQ/WAIT/PEND (2 bits) to param.v.
- One natural sub-module: if_out_buf, holding the output buffer and pend register with the hold/load/flush priority. The FSM and PC logic stay in if_fetch.

Test Plan:
- Reset release with zero-wait memory (ready=1, rvalid the cycle after acceptance) -> imem_addr sequence 0x0, 0x4, 0x8; pc_o/inst_o valid for one cycle each, every 2 cycles.
- Redirect to 0x100 while in S_WAIT, rvalid 3 cycles later with rdata 0xDEADBEEF -> that data is never presented; next imem_addr=0x100.
- stop_IF held 4 cycles while a response arrives -> data lands in pend, inst_valid stays high with the old instruction. After stop_IF falls, the pended instruction appears on the next edge with the correct pc.
- Redirect to 0x200 during S_PEND with stop_IF=1 -> pend dropped, inst_valid=0, inst_o=0x00000013; next request address 0x200.
- pc_q=0xFFFFFFFC fetched -> next imem_addr=0x00000000 (wrap).
- rst_n pulsed low while in S_WAIT, rvalid arriving after release -> ignored; imem_req low for the S_IDLE cycle, first address RESET_PC.
